// File: rtl/booth4_pkg.sv
// booth4_pkg: shared definitions for the radix-4 Booth multiplier.
//   booth_digit_e - recoded Booth digit (ZERO, POS1, POS2, NEG1, NEG2)
//   TAM_DEFAULT   - default operand width
//   booth_digit() - maps a 3-bit multiplier triplet {b[2i+1], b[2i], b[2i-1]} to a digit
package booth4_pkg;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } booth_digit_e;

  localparam int unsigned TAM_DEFAULT = 16;

  function automatic booth_digit_e booth_digit(input logic [2:0] trip);
    booth_digit_e d;
    case (trip)
      3'b001, 3'b010: d = POS1;
      3'b011:         d = POS2;
      3'b100:         d = NEG2;
      3'b101, 3'b110: d = NEG1;
      default:        d = ZERO;  // 000 and 111
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth4_pp.sv
// booth4_pp: one radix-4 Booth partial product, before its 2i positional shift.
//   A    [TAM-1:0]   multiplicand, signed
//   trip [2:0]       multiplier triplet {b[2i+1], b[2i], b[2i-1]}
//   pp   [2*TAM-1:0] digit * A, sign-extended to 2*TAM bits
module booth4_pp
  import booth4_pkg::*;
#(
  parameter int unsigned TAM = TAM_DEFAULT
) (
  input  logic [TAM-1:0]   A,
  input  logic [2:0]       trip,
  output logic [2*TAM-1:0] pp
);

  booth_digit_e     digit;
  logic [2*TAM-1:0] a_ext;
  logic [2*TAM-1:0] mag;

  assign a_ext = {{TAM{A[TAM-1]}}, A};

  always_comb begin
    digit = booth_digit(trip);
    mag   = a_ext;
    pp    = '0;
    if (digit == POS2 || digit == NEG2) begin
      mag = a_ext << 1;
    end
    case (digit)
      POS1, POS2: pp = mag;
      NEG1, NEG2: pp = ~mag + 1'b1;
      default:    pp = '0;
    endcase
  end

endmodule

// File: rtl/booth4_mult.sv
// booth4_mult: signed TAM x TAM radix-4 Booth multiplier.
//   clk, rst_n     clock, asynchronous active-low reset
//   A, B           signed operands (B is Booth-recoded)
//   in_valid       captures the current product into S_q
//   S              combinational 2*TAM product A*B
//   S_q            registered product
//   out_valid      S_q was captured on the previous edge
// Optional: define BOOTH4_SELFCHECK_EN to compile a simulation-only check of S
// against the behavioural product.
module booth4_mult
  import booth4_pkg::*;
#(
  parameter int unsigned TAM = TAM_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [TAM-1:0]     A,
  input  logic [TAM-1:0]     B,
  input  logic               in_valid,
  output logic [2*TAM-1:0]   S,
  output logic [2*TAM-1:0]   S_q,
  output logic               out_valid
);

  localparam int unsigned NPP = TAM / 2;

  // Appending the implicit B[-1] = 0 lets every triplet be a plain 3-bit slice.
  logic [TAM:0]       b_ext;
  logic [2*TAM-1:0]   pp [NPP];
  logic [2*TAM-1:0]   prod_d, prod_q;
  logic               valid_d, valid_q;

  assign b_ext = {B, 1'b0};

  for (genvar i = 0; i < NPP; i++) begin : g_pp
    booth4_pp #(.TAM(TAM)) u_pp (
      .A    (A),
      .trip (b_ext[2*i+2 : 2*i]),
      .pp   (pp[i])
    );
  end

  always_comb begin
    S = '0;
    for (int unsigned i = 0; i < NPP; i++) begin
      S = S + (pp[i] << (2 * i));
    end
  end

  always_comb begin
    prod_d  = prod_q;
    valid_d = in_valid;
    if (in_valid) begin
      prod_d = S;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      prod_q  <= prod_d;
      valid_q <= valid_d;
    end
  end

  assign S_q       = prod_q;
  assign out_valid = valid_q;

`ifdef BOOTH4_SELFCHECK_EN
  logic signed [2*TAM-1:0] selfcheck_exp;
  always @(A or B) begin
    #1;
    selfcheck_exp = $signed(A) * $signed(B);
    if (S !== selfcheck_exp) begin
      $error("booth4_mult selfcheck t=%0t A=%h B=%h S=%h expected=%h",
             $time, A, B, S, selfcheck_exp);
    end
  end
`else
`endif

endmodule

// File: tb/tb_booth4_mult.sv
// tb_booth4_mult: directed and random checks of booth4_mult (TAM = 16).
module tb_booth4_mult;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] A;
  logic [15:0] B;
  logic        in_valid;
  logic [31:0] S;
  logic [31:0] S_q;
  logic        out_valid;

  int checks = 0;
  int errors = 0;

  booth4_mult #(.TAM(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .A         (A),
    .B         (B),
    .in_valid  (in_valid),
    .S         (S),
    .S_q       (S_q),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_prod(input logic [15:0] a, input logic [15:0] b);
    longint pa, pb, p;
    pa = $signed(a);
    pb = $signed(b);
    p  = pa * pb;
    return p[31:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic unit(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic [31:0] exp);
    @(posedge clk);
    #1;
    A = a;
    B = b;
    @(negedge clk);
    chk(tag, S, exp);
  endtask

  initial begin
    rst_n    = 1'b0;
    A        = '0;
    B        = '0;
    in_valid = 1'b0;
    #12;
    chk("reset_S_q", S_q, 32'h0);
    chk("reset_out_valid", {31'b0, out_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    unit("one_one",   16'h0001, 16'h0001, 32'h0000_0001);
    unit("m1_one",    16'hFFFF, 16'h0001, 32'hFFFF_FFFF);
    unit("one_m1",    16'h0001, 16'hFFFF, 32'hFFFF_FFFF);
    unit("m1_m1",     16'hFFFF, 16'hFFFF, 32'h0000_0001);
    unit("zero_a",    16'h0000, 16'h0001, 32'h0000_0000);
    unit("zero_b",    16'hFFFF, 16'h0000, 32'h0000_0000);
    unit("min_min",   16'h8000, 16'h8000, 32'h4000_0000);
    unit("max_min",   16'h7FFF, 16'h8000, 32'hC000_8000);
    unit("max_max",   16'h7FFF, 16'h7FFF, 32'h3FFF_0001);

    // Random pairs, new values every two cycles, each also captured into S_q.
    for (int i = 0; i < 24; i++) begin
      logic [15:0] ra, rb;
      logic [31:0] rexp;
      ra   = 16'($urandom_range(1, 16'hFFFF));
      rb   = 16'($urandom_range(0, 16'hFFFF));
      rexp = ref_prod(ra, rb);
      @(posedge clk);
      #1;
      A        = ra;
      B        = rb;
      in_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("rand_S_%0d", i), S, rexp);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk($sformatf("rand_S_q_%0d", i), S_q, rexp);
      chk($sformatf("rand_vld_%0d", i), {31'b0, out_valid}, 32'h1);
    end

    // Register path: capture, then hold with in_valid low while operands move.
    @(posedge clk);
    #1;
    A        = 16'd3;
    B        = 16'hFFFB;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A        = 16'd7;
    B        = 16'd9;
    chk("reg_S_q", S_q, 32'hFFFF_FFF1);
    chk("reg_out_valid", {31'b0, out_valid}, 32'h1);
    @(posedge clk);
    #1;
    chk("hold_out_valid", {31'b0, out_valid}, 32'h0);
    chk("hold_S_q", S_q, 32'hFFFF_FFF1);
    chk("hold_S", S, 32'd63);

    // Asynchronous reset between edges while out_valid is high.
    A        = 16'h1234;
    B        = 16'h0010;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("pre_rst_vld", {31'b0, out_valid}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_S_q", S_q, 32'h0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    A = 16'hFF00;
    B = 16'h0123;
    #1;
    chk("rst_S_tracks", S, ref_prod(16'hFF00, 16'h0123));
    @(posedge clk);
    #1;
    chk("rst_hold_S_q", S_q, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_vld", {31'b0, out_valid}, 32'h0);
    chk("post_rst_S_q", S_q, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
